// File: rtl/addsub_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_accumulator
//
// Control/state stage upstream of an adder_subtractor. Accepts CLEAR, LOAD,
// ADD and SUB commands over a valid/ready handshake, applies each one to an
// N-bit accumulator and returns the new value plus carry, signed-overflow,
// zero and negative flags over a second valid/ready handshake.
//
// Configuration macro:
//   ADDSUB_ACC_SAT_EN  - when defined, an ADD/SUB that overflows saturates
//                        the accumulator to the most positive or most
//                        negative value instead of wrapping.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   cmd_valid_i  command present
//   cmd_ready_o  block can accept a command (IDLE)
//   cmd_op_i     00 CLEAR, 01 LOAD, 10 ADD, 11 SUB
//   cmd_data_i   operand, two's complement
//   res_valid_o  result present (RESP)
//   res_ready_i  consumer accepts the result
//   res_data_o   accumulator value after the command
//   res_carry_o  adder carry out (SUB: 1 = no borrow)
//   res_ovf_o    signed overflow of ADD/SUB
//   res_zero_o   res_data_o == 0
//   res_neg_o    res_data_o[N-1]
//   acc_o        live accumulator register
//
// Also contains adder_subtractor, the N-bit ripple add/subtract datapath.
// -----------------------------------------------------------------------------

module adder_subtractor #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] full_sum;

  // Subtraction is a + ~b + 1, so cout = 1 means no borrow.
  assign full_sum = {1'b0, a_i} + {1'b0, b_i ^ {N{sub_i}}} + {{N{1'b0}}, sub_i};
  assign sum_o    = full_sum[N-1:0];
  assign cout_o   = full_sum[N];

endmodule

module addsub_accumulator #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [1:0]   cmd_op_i,
  input  logic [N-1:0] cmd_data_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [N-1:0] res_data_o,
  output logic         res_carry_o,
  output logic         res_ovf_o,
  output logic         res_zero_o,
  output logic         res_neg_o,
  output logic [N-1:0] acc_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  logic [1:0]          state;
  logic [1:0]          op_p0;
  logic signed [N-1:0] data_p0;

  logic signed [N-1:0] acc_q;
  logic                carry_q;
  logic                ovf_q;
  logic                zero_q;
  logic                neg_q;

  logic [N-1:0]        sum;
  logic                cout;
  logic                sub;

  logic signed [N-1:0] nxt_acc;
  logic                nxt_carry;
  logic                nxt_ovf;

`ifdef ADDSUB_ACC_SAT_EN
  // Clamp toward the sign of the accumulator operand: the overflowed result
  // always has the opposite sign of a, so a's sign tells which rail to use.
  function automatic logic signed [N-1:0] sat_rail(input logic a_msb);
    sat_rail = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction
`endif

  assign sub = (op_p0 == OP_SUB);

  adder_subtractor #(.N(N)) u_addsub (
    .a_i    (acc_q),
    .b_i    (data_p0),
    .sub_i  (sub),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    nxt_acc   = acc_q;
    nxt_carry = 1'b0;
    nxt_ovf   = 1'b0;
    unique case (op_p0)
      OP_CLEAR: nxt_acc = '0;
      OP_LOAD:  nxt_acc = data_p0;
      default: begin
        nxt_acc   = sum;
        nxt_carry = cout;
        // ADD overflows when operand signs match, SUB when they differ, and
        // in both cases only if the result sign departs from a's sign.
        nxt_ovf   = ((acc_q[N-1] ^ data_p0[N-1]) == sub) &&
                    (sum[N-1] != acc_q[N-1]);
      end
    endcase
`ifdef ADDSUB_ACC_SAT_EN
    if (nxt_ovf) begin
      nxt_acc = sat_rail(acc_q[N-1]);
    end
`endif
  end

  // ---- stage p0: command capture (data only, no reset needed) ----
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && cmd_valid_i) begin
      op_p0   <= cmd_op_i;
      data_p0 <= cmd_data_i;
    end
  end

  // ---- stage p1: control FSM and result/accumulator registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_q   <= nxt_acc;
          carry_q <= nxt_carry;
          ovf_q   <= nxt_ovf;
          zero_q  <= (nxt_acc == '0);
          neg_q   <= nxt_acc[N-1];
          state   <= S_RESP;
        end
        S_RESP: begin
          if (res_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state == S_IDLE);
  assign res_valid_o = (state == S_RESP);
  assign res_data_o  = acc_q;
  assign acc_o       = acc_q;
  assign res_carry_o = carry_q;
  assign res_ovf_o   = ovf_q;
  assign res_zero_o  = zero_q;
  assign res_neg_o   = neg_q;

endmodule
